// File: rtl/uart_rx_sipo_os.sv
// rtl/uart_rx_sipo_os.sv - oversampling UART receive shift register with majority vote
//
// Purpose:
//   Synchronises the asynchronous rx line and detects the start edge.
//   Recovers each bit with a 2-of-3 vote around mid-bit.
//   Assembles a raw frame and checks parity and the stop bits.
//   Hands the frame to the deframe unit with a one-cycle def_en pulse.
//
// Ports:
//   baud_clk   - oversampling clock, OVERSAMPLE x bit rate
//   rst        - asynchronous active-high reset
//   rx         - asynchronous serial input, idles high
//   busy       - high while a frame is being received
//   data_out   - raw frame: bit 0 = start, data LSB-first, parity, MSB = last stop bit
//   def_en     - one-cycle pulse; data_out and the error flags are valid
//   parity_err - parity mismatch in the last frame
//   frame_err  - a stop bit of the last frame was sampled 0
module uart_rx_sipo_os #(
   parameter  int DATA_BITS  = 8,
   parameter  int PARITY_EN  = 1,
   parameter  int PARITY_ODD = 0,
   parameter  int STOP_BITS  = 1,
   parameter  int OVERSAMPLE = 16,
   localparam int FRAME_W    = 1 + DATA_BITS + PARITY_EN + STOP_BITS
) (
   input  logic               baud_clk,
   input  logic               rst,
   input  logic               rx,
   output logic               busy,
   output logic [FRAME_W-1:0] data_out,
   output logic               def_en,
   output logic               parity_err,
   output logic               frame_err
);

   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(FRAME_W);
   localparam logic [OS_W-1:0]  SAMP_A   = OS_W'(OVERSAMPLE/2 - 1);
   localparam logic [OS_W-1:0]  SAMP_B   = OS_W'(OVERSAMPLE/2);
   localparam logic [OS_W-1:0]  SAMP_C   = OS_W'(OVERSAMPLE/2 + 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);

   typedef enum logic [1:0] {IDLE, START, FRAME, DONE} state_t;

   state_t             state, state_nxt;
   logic               rx_meta, rxs;
   logic [OS_W-1:0]    os_cnt;
   logic [IDX_W-1:0]   bit_idx;
   logic               samp_a, samp_b;
   logic [FRAME_W-1:0] shadow, shadow_nxt;
   logic               armed;
   logic               decide, vote, store, last_bit, start_det;
   logic               par_calc;

   // Two-flop synchroniser; reset to the idle (high) line level.
   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // The third sample is the live rxs on the decision cycle.
   assign decide    = (os_cnt == SAMP_C);
   assign vote      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
   // A start needs a high sample seen since the last frame, so a held-low
   // (break) line cannot retrigger the receiver.
   assign start_det = (state == IDLE) && !rxs && armed;
   assign store     = decide && (((state == START) && !vote) || (state == FRAME));
   assign last_bit  = decide && (state == FRAME) && (bit_idx == IDX_LAST);

   always_comb begin
      shadow_nxt = shadow;
      if (bit_idx <= IDX_LAST) begin
         shadow_nxt[bit_idx] = vote;
      end
   end

   // XOR over data bits plus the parity bit (data only when parity is absent).
   assign par_calc = ^shadow_nxt[DATA_BITS+PARITY_EN:1];

   // State register
   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_det) state_nxt = START;
         START: if (decide)    state_nxt = vote ? IDLE : FRAME;
         FRAME: if (last_bit)  state_nxt = DONE;
         DONE:                 state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy   = 1'b0;
      def_en = 1'b0;
      case (state)
         START, FRAME: busy   = 1'b1;
         DONE:         def_en = 1'b1;
         default:      ;
      endcase
   end

   // Counters, sampling and the frame shadow.  The outputs load on the last
   // decision so they are already valid during the DONE cycle.
   always_ff @(posedge baud_clk or posedge rst) begin
      if (rst) begin
         os_cnt     <= '0;
         bit_idx    <= '0;
         samp_a     <= 1'b0;
         samp_b     <= 1'b0;
         shadow     <= '0;
         armed      <= 1'b0;
         data_out   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if ((state == START) || (state == FRAME)) begin
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
         end else begin
            os_cnt <= '0;
         end

         if (os_cnt == SAMP_A) samp_a <= rxs;
         if (os_cnt == SAMP_B) samp_b <= rxs;

         if (state == IDLE) begin
            bit_idx <= '0;
         end else if (store) begin
            bit_idx <= bit_idx + 1'b1;
         end

         if (store) begin
            shadow <= shadow_nxt;
         end

         if (start_det) begin
            armed <= 1'b0;
         end else if (((state == IDLE) || (state == DONE)) && rxs) begin
            armed <= 1'b1;
         end

         if (last_bit) begin
            data_out   <= shadow_nxt;
            parity_err <= (PARITY_EN != 0) && (par_calc != 1'(PARITY_ODD));
            frame_err  <= ~&shadow_nxt[FRAME_W-1 -: STOP_BITS];
         end
      end
   end

endmodule

// File: doc/uart_rx_sipo_os.md
Name: uart_rx_sipo_os

Overview:
- Parametrised oversampling serial-in/parallel-out receiver for the full-duplex UART IP core. Successor to the fixed 11-bit receive shift register.
- Synchronises the asynchronous rx line and detects the start edge. Each bit is recovered by majority vote at mid-bit.
- Assembles a configurable frame, checks parity and stop bits, and hands the raw frame to the deframe unit with a one-cycle enable.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY_EN, 1, 1 = parity bit present after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- OVERSAMPLE, 16, baud_clk cycles per bit; even, minimum 8.
- FRAME_W, derived: 1 + DATA_BITS + PARITY_EN + STOP_BITS (11 at defaults).

Ports:
- baud_clk  in  1  oversampling clock, OVERSAMPLE x bit rate.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous, idles high.
- busy  out  1  high while a frame is being received.
- data_out  out  FRAME_W  raw frame: bit 0 = start, then data LSB-first, then parity, MSB = last stop bit.
- def_en  out  1  one-cycle pulse; data_out and the error flags are valid.
- parity_err  out  1  parity mismatch in the last frame.
- frame_err  out  1  any stop bit of the last frame sampled 0.

Behaviour:
- Reset values (async, rst = 1):
  - busy = 0, def_en = 0, data_out = 0, parity_err = 0, frame_err = 0.
  - Both synchroniser flops = 1, state = IDLE, all counters = 0.
  - Reset asserted mid-frame aborts the frame with no def_en pulse.
- Synchroniser: two flops on rx; all logic uses the synced value rxs. Latency is 2 cycles.
- Counters:
  - os_cnt counts 0..OVERSAMPLE-1 and wraps.
  - Three samples are taken at os_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, decided at os_cnt = OVERSAMPLE/2+1 (the decision cycle).
- State IDLE: busy = 0. rxs = 0 -> START, os_cnt = 0, bit_idx = 0.
- State START: busy = 1. At the decision cycle:
  - vote = 0 -> store 0 in data_out shadow bit 0, bit_idx = 1, go to FRAME.
  - vote = 1 -> false start: back to IDLE, no pulse, outputs unchanged.
- State FRAME: busy = 1.
  - At each decision cycle, store the vote at shadow[bit_idx] and increment bit_idx.
  - The decision for bit_idx = FRAME_W-1 goes to DONE; the frame closes at mid-stop-bit.
- State DONE, 1 cycle:
  - busy = 0, def_en = 1.
  - data_out, parity_err and frame_err load from the shadow register and the checks.
  - Next state is IDLE; a new start can be detected on the following cycle (back-to-back frames).
- def_en is high for exactly one cycle per accepted frame. It asserts one cycle after the last stop-bit decision cycle.
- data_out and both error flags hold their values until the next DONE.
- Parity check: parity_err = (XOR of data bits and parity bit) != PARITY_ODD. parity_err is forced to 0 when PARITY_EN = 0.
- Frame check: frame_err = 1 if any stop-bit vote = 0. A break condition (line held low) yields frame_err = 1 and data bits 0; the receiver then waits in IDLE until rxs returns high. A new frame needs a fresh low after at least one high sample.
- Glitch tolerance: a single deviating sample among the three does not change the vote.
- Framing errors are not fatal; the frame is still delivered.

Test Plan:
- Defaults, rx sends 0x55 with even parity (bits 0,1,0,1,0,1,0,1,0,0,1) at 16 cycles/bit -> one def_en pulse, data_out = 11'h4AA, parity_err = 0, frame_err = 0, busy low after the pulse.
- Same frame with the parity bit flipped to 1 -> data_out = 11'h6AA, parity_err = 1, frame_err = 0.
- rx low for 5 cycles, then high (glitch start) -> START aborts at the first decision cycle, no def_en, busy returns to 0, data_out unchanged.
- Stop bit driven 0 followed by line held low (break) -> frame_err = 1, data bits 0. No second frame until rx goes high and then low again.
- One-cycle inverted pulse placed on the middle sample of data bit 3 -> data received correctly, no errors.
- rst pulsed during data bit 4 -> all outputs 0 immediately. The next clean 0xA3 frame is received correctly: data_out[8:1] = 8'hA3, parity_err = 0.
- Two frames back-to-back with no idle gap -> two def_en pulses, both payloads correct.
